beeb_bus_queue: RTL and testbench
=================================

# beeb_bus_queue

Posted-write queue and external bus cycle sequencer between the accelerated 65C02 core and the slow host (BBC/Master/Elk) bus. The core hands every external access to this block over a single valid/ready port. Ordinary writes are buffered and drained one per host bus cycle, so the core keeps running at full speed. Reads and I/O-page writes are non-posted: they are issued only after all buffered writes have drained, and are acknowledged only when their host bus cycle completes.

## Interface
Parameters:
- DEPTH, 4, number of posted-write entries; power of two, 2..16
- IO_PAGE_LO, 8'hFC, first page whose writes are non-posted
- IO_PAGE_HI, 8'hFE, last page whose writes are non-posted

Ports:
- cpu_clk  in  1  core clock; the only clock
- cpu_reset  in  1  synchronous, active-high reset
- req_valid  in  1  core presents an external access
- req_we  in  1  1 = write, 0 = read
- req_addr  in  16  access address
- req_wdata  in  8  write data
- req_ready  out  1  access consumed this cycle
- rd_data  out  8  read result; valid in the ack cycle and held until the next read completes
- bus_start  in  1  one-cycle pulse at the start of each host bus slot
- bus_end  in  1  one-cycle pulse at the end of each host bus slot
- bus_din  in  8  host data, already sampled; valid in the bus_end cycle
- beeb_AB  out  16  host address
- beeb_WE  out  1  host write strobe
- beeb_DO  out  8  host write data
- empty  out  1  queue empty and no slot in flight (used to gate shadow/ROM latch changes)

## Operation
- Request classes:
  - posted: req_we=1 and req_addr[15:8] outside IO_PAGE_LO..IO_PAGE_HI
  - non-posted: a read, or a write whose page is inside that range
- Posted write:
  - req_ready = (count < DEPTH), combinationally.
  - On valid&&ready, {addr, data} is pushed at the tail.
- Non-posted access:
  - req_ready stays low until the access completes.
  - The block latches it internally; the np_issued flag prevents a second issue while req_valid is held.
- Slot scheduler runs at each bus_start, using registered state:
  - If count > 0: pop the head and drive beeb_AB/beeb_WE=1/beeb_DO; state WR.
  - Else if a non-posted access is pending and not yet issued: drive it; state NP; set np_issued.
  - Else: drive idle values (FFFF/0/FF); state IDLE.
- States: IDLE, WR, NP, ACK.
  - WR → IDLE at bus_end.
  - NP → ACK at bus_end. If the access is a read, rd_data <= bus_din in that cycle.
  - ACK lasts exactly one cycle. In ACK, req_ready=1, then np_issued clears and the state returns to IDLE.
  - Bus outputs keep their values until the next bus_start (hold time).
- Ordering: host bus order equals core request order. A non-posted access never overtakes a buffered write.
- count arithmetic:
  - count_next = count + push − pop, with width log2(DEPTH)+1.
  - Head and tail pointers have width log2(DEPTH) and wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
- empty = (count==0) && state==IDLE && no pending non-posted access.

## Timing
- Reset values: beeb_AB=16'hFFFF, beeb_WE=0, beeb_DO=8'hFF, rd_data=8'hFF, req_ready=0 unless a posted write is presented, empty=1, count=0, state IDLE.
- Reset mid-slot:
  - Queue contents are discarded.
  - Bus outputs return to idle values the cycle after cpu_reset is sampled high.
  - A pending non-posted access is dropped with no ack.
- Posted write latency:
  - Accepted in the same cycle it is presented.
  - It appears on the bus at the first bus_start strictly after acceptance. A push in a bus_start cycle with the queue empty waits for the next slot.
- Non-posted latency:
  - Issue at the first bus_start that finds count==0 with the access registered pending.
  - Ack (req_ready) is one cycle after that slot's bus_end.
- Full queue: req_ready=0 for posted writes. A pop at bus_start raises req_ready the following cycle.
- bus_start and bus_end in the same cycle: end processing for the current slot happens first, then the new slot is scheduled. A slot in state NP ends as ACK, so nothing new is issued in that cycle.
- bus_end while in IDLE: ignored.

## Test plan
- Reset, then a posted write to 16'h3000 with data 8'h55 → req_ready high the same cycle; at the next bus_start, beeb_AB=3000, beeb_WE=1, beeb_DO=55; after bus_end, empty=1.
- Five back-to-back posted writes with DEPTH=4, no bus_start → the first four are accepted and the fifth stalls with req_ready=0; after one bus_start the fifth is accepted on the following cycle; the host bus sees all five addresses in order.
- Two posted writes, then a read of 16'hFE40 with bus_din=8'hA7 → the read is issued only in the third slot; req_ready pulses one cycle after that slot's bus_end; rd_data=A7.
- Write to 16'hFE40 with data 8'h0F → req_ready stays 0 until one cycle after its bus_end; it is never queued; req_valid held through the ack issues exactly one host cycle.
- Pointer wrap: 10 writes interleaved with slots at DEPTH=4 → the bus sequence matches the input sequence exactly; count never exceeds 4.
- cpu_reset asserted mid-slot with three entries queued → the next cycle shows beeb_AB=FFFF, beeb_WE=0, empty=1; later bus_start pulses produce idle slots only.

Source files
------------

// File: rtl/beeb_bus_queue.sv
// beeb_bus_queue: posted-write FIFO plus host bus slot sequencer between
// the fast 65C02 core and the slow host bus.
// Ports:
//   cpu_clk, cpu_reset             clock, synchronous active-high reset
//   req_valid/we/addr/wdata/ready  core access port (valid/ready)
//   rd_data                        read result, held until next read ack
//   bus_start, bus_end, bus_din    host slot pulses and sampled host data
//   beeb_AB, beeb_WE, beeb_DO      host bus address, write strobe, data
//   empty                          no queued writes, no slot, no pending access
module beeb_bus_queue #(
   parameter int          DEPTH      = 4,
   parameter logic [7:0]  IO_PAGE_LO = 8'hFC,
   parameter logic [7:0]  IO_PAGE_HI = 8'hFE
) (
   input  logic        cpu_clk,
   input  logic        cpu_reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        req_ready,
   output logic [7:0]  rd_data,
   input  logic        bus_start,
   input  logic        bus_end,
   input  logic [7:0]  bus_din,
   output logic [15:0] beeb_AB,
   output logic        beeb_WE,
   output logic [7:0]  beeb_DO,
   output logic        empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

   typedef enum logic [1:0] {IDLE, WR, NP, ACK} state_t;

   state_t state, state_mid, state_nx;

   logic [15:0]   q_addr [DEPTH];
   logic [7:0]    q_data [DEPTH];
   logic [AW-1:0] head, tail;
   logic [AW:0]   count, inc, dec;

   logic        np_pend, np_issued, np_we;
   logic [15:0] np_addr;
   logic [7:0]  np_data;

   logic io_page, posted, full, push, np_take;
   logic sched, pop, issue;

   assign io_page = (req_addr[15:8] >= IO_PAGE_LO) &&
                    (req_addr[15:8] <= IO_PAGE_HI);
   assign posted  = req_we && !io_page;
   assign full    = (count == FULL);
   assign push    = req_valid && posted && !full;
   // A held non-posted request is captured once; np_pend guards re-capture.
   assign np_take = req_valid && !posted && !np_pend;

   assign req_ready = (req_valid && posted) ? !full : (state == ACK);
   assign empty     = (count == '0) && (state == IDLE) && !np_pend;

   assign inc = {{AW{1'b0}}, push};
   assign dec = {{AW{1'b0}}, pop};

   // End-of-slot processing happens first; a new slot is only scheduled
   // if that leaves the sequencer idle (an NP slot ending goes to ACK).
   always_comb begin
      state_mid = state;
      unique case (state)
         WR:      if (bus_end) state_mid = IDLE;
         NP:      if (bus_end) state_mid = ACK;
         ACK:     state_mid = IDLE;
         default: state_mid = IDLE;
      endcase
      sched = bus_start && (state_mid == IDLE);
      pop   = sched && (count != '0);
      issue = sched && (count == '0) && np_pend && !np_issued;
      state_nx = state_mid;
      if (sched) state_nx = pop ? WR : (issue ? NP : IDLE);
   end

   always_ff @(posedge cpu_clk) begin
      if (push) begin
         q_addr[tail] <= req_addr;
         q_data[tail] <= req_wdata;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_reset) begin
         state     <= IDLE;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         np_pend   <= 1'b0;
         np_issued <= 1'b0;
         np_we     <= 1'b0;
         np_addr   <= '0;
         np_data   <= '0;
         rd_data   <= 8'hFF;
         beeb_AB   <= 16'hFFFF;
         beeb_WE   <= 1'b0;
         beeb_DO   <= 8'hFF;
      end else begin
         state <= state_nx;
         count <= count + inc - dec;
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;

         if (np_take) begin
            np_pend <= 1'b1;
            np_we   <= req_we;
            np_addr <= req_addr;
            np_data <= req_wdata;
         end
         if (issue) np_issued <= 1'b1;
         if (state == ACK) begin
            np_pend   <= 1'b0;
            np_issued <= 1'b0;
         end

         if (state == NP && bus_end && !np_we) rd_data <= bus_din;

         // Bus outputs only change at a scheduled slot start.
         if (sched) begin
            unique case (1'b1)
               pop: begin
                  beeb_AB <= q_addr[head];
                  beeb_WE <= 1'b1;
                  beeb_DO <= q_data[head];
               end
               issue: begin
                  beeb_AB <= np_addr;
                  beeb_WE <= np_we;
                  beeb_DO <= np_we ? np_data : 8'hFF;
               end
               default: begin
                  beeb_AB <= 16'hFFFF;
                  beeb_WE <= 1'b0;
                  beeb_DO <= 8'hFF;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_beeb_bus_queue.sv
// tb_beeb_bus_queue: directed and randomized checks of beeb_bus_queue
// against a transaction-order reference model.
module tb_beeb_bus_queue;

   logic        clk = 1'b0;
   logic        cpu_reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [7:0]  req_wdata = '0;
   logic        req_ready;
   logic [7:0]  rd_data;
   logic        bus_start = 1'b0;
   logic        bus_end = 1'b0;
   logic [7:0]  bus_din = '0;
   logic [15:0] beeb_AB;
   logic        beeb_WE;
   logic [7:0]  beeb_DO;
   logic        empty;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  data;
   } acc_t;

   acc_t obs[$];
   int   n_obs_posted = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   core_done;

   beeb_bus_queue dut (
      .cpu_clk   (clk),
      .cpu_reset (cpu_reset),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rd_data   (rd_data),
      .bus_start (bus_start),
      .bus_end   (bus_end),
      .bus_din   (bus_din),
      .beeb_AB   (beeb_AB),
      .beeb_WE   (beeb_WE),
      .beeb_DO   (beeb_DO),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   // Record every non-idle host slot in the order it appears.
   always @(posedge clk) begin
      if (bus_start && !cpu_reset) begin
         #1;
         if (beeb_AB !== 16'hFFFF || beeb_WE !== 1'b0) begin
            obs.push_back({beeb_WE, beeb_AB, beeb_DO});
            if (beeb_WE && !(beeb_AB[15:8] inside {[8'hFC:8'hFE]}))
               n_obs_posted++;
         end
      end
   end

   function automatic logic [7:0] din_of(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic slot_begin();
      bus_start = 1'b1;
      tick();
      bus_start = 1'b0;
   endtask

   task automatic slot_finish();
      bus_end = 1'b1;
      tick();
      bus_end = 1'b0;
   endtask

   task automatic drive(input logic we, input logic [15:0] a,
                        input logic [7:0] d);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
   endtask

   task automatic test_reset();
      cpu_reset = 1'b1;
      tick();
      tick();
      cpu_reset = 1'b0;
      #1;
      n_cmp++; if (beeb_AB !== 16'hFFFF) begin n_bad++; $display("FAIL rst_ab got %h exp FFFF", beeb_AB); end
      n_cmp++; if (beeb_WE !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b exp 0", beeb_WE); end
      n_cmp++; if (beeb_DO !== 8'hFF) begin n_bad++; $display("FAIL rst_do got %h exp FF", beeb_DO); end
      n_cmp++; if (rd_data !== 8'hFF) begin n_bad++; $display("FAIL rst_rd got %h exp FF", rd_data); end
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %b exp 1", empty); end
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b exp 0", req_ready); end
      tick();
   endtask

   task automatic test_posted();
      drive(1'b1, 16'h3000, 8'h55);
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_ready got %b exp 1", req_ready); end
      tick();
      req_valid = 1'b0;
      n_cmp++; if (beeb_AB !== 16'hFFFF) begin n_bad++; $display("FAIL post_early got %h exp FFFF", beeb_AB); end
      n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL post_busy got %b exp 0", empty); end
      slot_begin();
      n_cmp++; if ({beeb_AB, beeb_WE, beeb_DO} !== {16'h3000, 1'b1, 8'h55}) begin n_bad++; $display("FAIL post_bus got %h/%b/%h exp 3000/1/55", beeb_AB, beeb_WE, beeb_DO); end
      slot_finish();
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL post_empty got %b exp 1", empty); end
      n_cmp++; if (beeb_AB !== 16'h3000) begin n_bad++; $display("FAIL post_hold got %h exp 3000", beeb_AB); end
      // push in the same cycle as a slot start with an empty queue
      drive(1'b1, 16'h3001, 8'h66);
      bus_start = 1'b1;
      tick();
      bus_start = 1'b0;
      req_valid = 1'b0;
      n_cmp++; if (beeb_AB !== 16'hFFFF || beeb_WE !== 1'b0) begin n_bad++; $display("FAIL post_wait got %h/%b exp FFFF/0", beeb_AB, beeb_WE); end
      slot_finish();
      slot_begin();
      n_cmp++; if ({beeb_AB, beeb_DO} !== {16'h3001, 8'h66}) begin n_bad++; $display("FAIL post_next got %h/%h exp 3001/66", beeb_AB, beeb_DO); end
      slot_finish();
   endtask

   task automatic test_full();
      acc_t exp_q[$];
      obs.delete();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 16'h1000 + 16'(i), 8'(8'h20 + i));
         exp_q.push_back({1'b1, 16'h1000 + 16'(i), 8'(8'h20 + i)});
         #1;
         n_cmp++; if (req_ready !== (i < 4)) begin n_bad++; $display("FAIL full_ready%0d got %b exp %b", i, req_ready, (i < 4)); end
         if (i < 4) tick();
      end
      bus_start = 1'b1;
      tick();
      bus_start = 1'b0;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL full_reopen got %b exp 1", req_ready); end
      tick();
      req_valid = 1'b0;
      n_cmp++; if (beeb_AB !== 16'h1000) begin n_bad++; $display("FAIL full_first got %h exp 1000", beeb_AB); end
      slot_finish();
      for (int i = 0; i < 4; i++) begin
         slot_begin();
         slot_finish();
      end
      n_cmp++; if (obs.size() != 5) begin n_bad++; $display("FAIL full_count got %0d exp 5", obs.size()); end
      for (int i = 0; i < 5 && i < obs.size(); i++) begin
         n_cmp++; if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL full_order%0d got %h exp %h", i, obs[i], exp_q[i]); end
      end
   endtask

   task automatic test_read();
      logic [15:0] ea [3];
      ea[0] = 16'h2000; ea[1] = 16'h2001; ea[2] = 16'hFE40;
      drive(1'b1, 16'h2000, 8'hA0);
      tick();
      drive(1'b1, 16'h2001, 8'hA1);
      tick();
      drive(1'b0, 16'hFE40, 8'h00);
      bus_din = 8'hA7;
      for (int k = 0; k < 3; k++) begin
         slot_begin();
         n_cmp++; if (beeb_AB !== ea[k] || beeb_WE !== (k < 2)) begin n_bad++; $display("FAIL rd_slot%0d got %h/%b exp %h/%b", k, beeb_AB, beeb_WE, ea[k], (k < 2)); end
         n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rd_early%0d got %b exp 0", k, req_ready); end
         tick();
         slot_finish();
         n_cmp++; if (req_ready !== (k == 2)) begin n_bad++; $display("FAIL rd_ack%0d got %b exp %b", k, req_ready, (k == 2)); end
      end
      n_cmp++; if (rd_data !== 8'hA7) begin n_bad++; $display("FAIL rd_data got %h exp A7", rd_data); end
      tick();
      req_valid = 1'b0;
      bus_din = 8'h00;
      #1;
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rd_pulse got %b exp 0", req_ready); end
      n_cmp++; if (rd_data !== 8'hA7) begin n_bad++; $display("FAIL rd_hold got %h exp A7", rd_data); end
   endtask

   task automatic test_io_write();
      drive(1'b1, 16'hFE40, 8'h0F);
      #1;
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL io_ready got %b exp 0", req_ready); end
      tick();
      n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL io_pend got %b exp 0", empty); end
      slot_begin();
      n_cmp++; if ({beeb_AB, beeb_WE, beeb_DO} !== {16'hFE40, 1'b1, 8'h0F}) begin n_bad++; $display("FAIL io_bus got %h/%b/%h exp FE40/1/0F", beeb_AB, beeb_WE, beeb_DO); end
      tick();
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL io_wait got %b exp 0", req_ready); end
      slot_finish();
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL io_ack got %b exp 1", req_ready); end
      // a slot starting during the ack cycle must not reissue the access
      bus_start = 1'b1;
      tick();
      bus_start = 1'b0;
      req_valid = 1'b0;
      n_cmp++; if (beeb_AB !== 16'hFFFF || beeb_WE !== 1'b0) begin n_bad++; $display("FAIL io_once got %h/%b exp FFFF/0", beeb_AB, beeb_WE); end
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL io_empty got %b exp 1", empty); end
      slot_finish();
   endtask

   task automatic test_same_cycle();
      drive(1'b1, 16'h4000, 8'h11);
      tick();
      req_valid = 1'b0;
      slot_begin();
      drive(1'b1, 16'h4001, 8'h22);
      tick();
      req_valid = 1'b0;
      bus_start = 1'b1;
      bus_end = 1'b1;
      tick();
      bus_start = 1'b0;
      bus_end = 1'b0;
      n_cmp++; if ({beeb_AB, beeb_WE, beeb_DO} !== {16'h4001, 1'b1, 8'h22}) begin n_bad++; $display("FAIL sc_wr got %h/%b/%h exp 4001/1/22", beeb_AB, beeb_WE, beeb_DO); end
      slot_finish();
      drive(1'b0, 16'h5123, 8'h00);
      tick();
      slot_begin();
      bus_din = 8'h3C;
      bus_start = 1'b1;
      bus_end = 1'b1;
      tick();
      bus_start = 1'b0;
      bus_end = 1'b0;
      n_cmp++; if (beeb_AB !== 16'h5123 || beeb_WE !== 1'b0) begin n_bad++; $display("FAIL sc_np_hold got %h/%b exp 5123/0", beeb_AB, beeb_WE); end
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL sc_ack got %b exp 1", req_ready); end
      n_cmp++; if (rd_data !== 8'h3C) begin n_bad++; $display("FAIL sc_rd got %h exp 3C", rd_data); end
      tick();
      req_valid = 1'b0;
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL sc_empty got %b exp 1", empty); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'h6000 + 16'(i), 8'(i));
         tick();
      end
      drive(1'b0, 16'h7000, 8'h00);
      slot_begin();
      cpu_reset = 1'b1;
      req_valid = 1'b0;
      tick();
      cpu_reset = 1'b0;
      obs.delete();
      n_cmp++; if (beeb_AB !== 16'hFFFF || beeb_WE !== 1'b0 || beeb_DO !== 8'hFF) begin n_bad++; $display("FAIL rm_bus got %h/%b/%h exp FFFF/0/FF", beeb_AB, beeb_WE, beeb_DO); end
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rm_empty got %b exp 1", empty); end
      for (int k = 0; k < 3; k++) begin
         slot_begin();
         n_cmp++; if (beeb_AB !== 16'hFFFF || beeb_WE !== 1'b0) begin n_bad++; $display("FAIL rm_idle%0d got %h/%b exp FFFF/0", k, beeb_AB, beeb_WE); end
         n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rm_noack%0d got %b exp 0", k, req_ready); end
         slot_finish();
      end
      n_cmp++; if (obs.size() != 0) begin n_bad++; $display("FAIL rm_slots got %0d exp 0", obs.size()); end
   endtask

   task automatic test_wrap_random();
      for (int p = 0; p < 2; p++) begin
         acc_t exp_q[$];
         int   n_acc;
         int   nreq;
         nreq = (p == 0) ? 10 : 30;
         n_acc = 0;
         obs.delete();
         n_obs_posted = 0;
         core_done = 1'b0;
         fork
            begin : core
               for (int i = 0; i < nreq; i++) begin
                  acc_t r;
                  bit   got;
                  bit   pst;
                  int   kind;
                  kind = (p == 0) ? 0 : $urandom_range(0, 5);
                  if (kind <= 2) begin
                     r = {1'b1, 8'($urandom_range(0, 251)), 8'($urandom), 8'($urandom)};
                     pst = 1'b1;
                  end else if (kind <= 4) begin
                     r = {1'b0, 8'($urandom_range(0, 254)), 8'($urandom), 8'hFF};
                     pst = 1'b0;
                  end else begin
                     r = {1'b1, 8'($urandom_range(252, 254)), 8'($urandom), 8'($urandom)};
                     pst = 1'b0;
                  end
                  exp_q.push_back(r);
                  drive(r.we, r.addr, r.data);
                  got = 1'b0;
                  for (int k = 0; k < 300 && !got; k++) begin
                     @(negedge clk);
                     if (pst) begin
                        n_cmp++; if (req_ready !== ((n_acc - n_obs_posted) < 4)) begin n_bad++; $display("FAIL rnd_ready p%0d req%0d got %b exp %b", p, i, req_ready, ((n_acc - n_obs_posted) < 4)); end
                     end
                     if (req_ready === 1'b1) begin
                        got = 1'b1;
                        if (!r.we) begin
                           n_cmp++; if (rd_data !== din_of(r.addr)) begin n_bad++; $display("FAIL rnd_rd req%0d got %h exp %h", i, rd_data, din_of(r.addr)); end
                        end
                     end
                     @(posedge clk);
                     #1;
                  end
                  if (got && pst) n_acc++;
                  if (!got) begin
                     n_bad++;
                     $display("FAIL rnd_timeout req%0d got no ready exp ready", i);
                  end
                  req_valid = 1'b0;
                  repeat ($urandom_range(0, 2)) tick();
               end
               core_done = 1'b1;
            end
            begin : bus
               int cyc;
               cyc = 0;
               while ((!core_done || empty !== 1'b1) && cyc < 4000) begin
                  repeat ($urandom_range(0, 3)) begin tick(); cyc++; end
                  slot_begin();
                  cyc++;
                  repeat ($urandom_range(0, 2)) begin tick(); cyc++; end
                  bus_din = din_of(beeb_AB);
                  slot_finish();
                  cyc++;
               end
               if (cyc >= 4000) begin
                  n_bad++;
                  $display("FAIL rnd_drain got busy exp empty");
               end
            end
         join
         n_cmp++; if (obs.size() != exp_q.size()) begin n_bad++; $display("FAIL rnd_count p%0d got %0d exp %0d", p, obs.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i].we !== exp_q[i].we || obs[i].addr !== exp_q[i].addr ||
                (exp_q[i].we && obs[i].data !== exp_q[i].data)) begin
               n_bad++;
               $display("FAIL rnd_order p%0d #%0d got %h exp %h", p, i, obs[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_posted();
      test_full();
      test_read();
      test_io_write();
      test_same_cycle();
      test_reset_mid();
      test_wrap_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
